// File: rtl/shape_pkg.sv
// rtl/shape_pkg.sv - shared types and constants for the shape processor config arbiter
package shape_pkg;

  typedef logic [1:0] shape_t;
  typedef logic [5:0] operation_t;

  localparam shape_t     SHAPE_KEEP  = 2'b11;
  localparam operation_t OP_KEEP     = 6'h3F;
  localparam int         SHAPE_LSB   = 16;
  localparam int         OP_LSB      = 0;
  localparam shape_t     SHAPE_RESET = 2'b01;
  localparam operation_t OP_RESET    = 6'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_WRITE,
    ST_CHECK,
    ST_RESP
  } fsm_state_t;

  function automatic logic [31:0] pack_sfr(input shape_t s, input operation_t o);
    return (32'(s) << SHAPE_LSB) | (32'(o) << OP_LSB);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at rr_ptr
module rr_arbiter
  import shape_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               any_valid
);

  int idx;

  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        grant     = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/shape_cfg_arbiter.sv
// rtl/shape_cfg_arbiter.sv - arbitrates requesters onto the shape processor SFR port
module shape_cfg_arbiter
  import shape_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_shape,
  input  logic [6*NUM_REQ-1:0] req_op,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic                 rsp_ok,
  output logic [7:0]           rsp_data,
  output logic                 sp_write,
  output logic [31:0]          sp_write_data,
  output logic                 sp_read,
  input  logic [31:0]          sp_read_data,
  output logic                 busy,
  output logic [CNT_W-1:0]     reject_count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  fsm_state_t       state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, grant, pick;
  logic             any_valid;
  shape_t           req_shape_r, pre_shape, pick_shape, exp_shape;
  operation_t       req_op_r, pre_op, pick_op, exp_op;
  logic [7:0]       post_r, post_d;
  logic             ok_r;
  logic             unused_read_bits;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (pick),
    .any_valid (any_valid)
  );

  always_comb begin
    pick_shape = req_shape[1:0];
    pick_op    = req_op[5:0];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IDX_W'(i)) begin
        pick_shape = req_shape[2*i +: 2];
        pick_op    = req_op[6*i +: 6];
      end
    end
  end

  // Keep codes resolve against the value captured before the write.
  assign exp_shape = (req_shape_r == SHAPE_KEEP) ? pre_shape : req_shape_r;
  assign exp_op    = (req_op_r == OP_KEEP) ? pre_op : req_op_r;
  assign post_d    = {sp_read_data[SHAPE_LSB +: 2], sp_read_data[OP_LSB +: 6]};
  assign unused_read_bits = ^{sp_read_data[31:18], sp_read_data[15:6]};

  assign busy     = (state != ST_IDLE);
  assign rsp_ok   = ok_r;
  assign rsp_data = post_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    sp_read       = 1'b0;
    sp_write      = 1'b0;
    sp_write_data = '0;
    rsp_valid     = '0;
    case (state)
      ST_IDLE:    if (any_valid) state_nxt = ST_CAPTURE;
      ST_CAPTURE: begin
        sp_read   = 1'b1;
        state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        sp_write      = 1'b1;
        sp_write_data = pack_sfr(req_shape_r, req_op_r);
        state_nxt     = ST_CHECK;
      end
      ST_CHECK: begin
        sp_read   = 1'b1;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        for (int i = 0; i < NUM_REQ; i++) rsp_valid[i] = (grant == IDX_W'(i));
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      grant        <= '0;
      req_shape_r  <= '0;
      req_op_r     <= '0;
      pre_shape    <= '0;
      pre_op       <= '0;
      post_r       <= '0;
      ok_r         <= 1'b0;
      reject_count <= '0;
    end else begin
      case (state)
        ST_IDLE: if (any_valid) begin
          grant       <= pick;
          req_shape_r <= pick_shape;
          req_op_r    <= pick_op;
        end
        ST_CAPTURE: begin
          pre_shape <= sp_read_data[SHAPE_LSB +: 2];
          pre_op    <= sp_read_data[OP_LSB +: 6];
        end
        ST_CHECK: begin
          post_r <= post_d;
          ok_r   <= (post_d == {exp_shape, exp_op});
        end
        ST_RESP: begin
          if (!ok_r && (reject_count != '1)) reject_count <= reject_count + 1'b1;
          rr_ptr <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shape_cfg_arbiter.sv
// tb/tb_shape_cfg_arbiter.sv - scoreboard bench for shape_cfg_arbiter
module tb_shape_cfg_arbiter;
  import shape_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic p_rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid;
  logic [2*N-1:0] req_shape;
  logic [6*N-1:0] req_op;
  logic [N-1:0]   rsp_valid;
  logic           rsp_ok;
  logic [7:0]     rsp_data;
  logic           sp_write, sp_read, busy;
  logic [31:0]    sp_write_data, sp_read_data;
  logic [15:0]    reject_count;

  shape_cfg_arbiter #(.NUM_REQ(N), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_shape(req_shape), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .rsp_data(rsp_data), .sp_write(sp_write),
    .sp_write_data(sp_write_data), .sp_read(sp_read), .sp_read_data(sp_read_data),
    .busy(busy), .reject_count(reject_count)
  );

  logic [1:0]  s_req, s_rsp_valid;
  logic [3:0]  s_shape;
  logic [11:0] s_op;
  logic        s_rsp_ok, s_sp_write, s_sp_read, s_busy;
  logic [7:0]  s_rsp_data;
  logic [31:0] s_sp_write_data;
  logic [1:0]  s_reject_count;

  shape_cfg_arbiter #(.NUM_REQ(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(s_req), .req_shape(s_shape), .req_op(s_op),
    .rsp_valid(s_rsp_valid), .rsp_ok(s_rsp_ok), .rsp_data(s_rsp_data), .sp_write(s_sp_write),
    .sp_write_data(s_sp_write_data), .sp_read(s_sp_read), .sp_read_data(32'h0),
    .busy(s_busy), .reject_count(s_reject_count)
  );

  // Processor model: shape 01 forbids any op with bit 5 set; rejected writes leave state unchanged.
  shape_t     p_shape;
  operation_t p_op;
  assign sp_read_data = {14'b0, p_shape, 10'b0, p_op};

  function automatic shape_t res_s(input logic [31:0] wd, input shape_t cur);
    return (wd[17:16] == SHAPE_KEEP) ? cur : wd[17:16];
  endfunction
  function automatic operation_t res_o(input logic [31:0] wd, input operation_t cur);
    return (wd[5:0] == OP_KEEP) ? cur : wd[5:0];
  endfunction
  function automatic logic legal(input shape_t s, input operation_t o);
    return !(s == 2'b01 && o[5]);
  endfunction

  always @(posedge clk or negedge p_rst_n) begin
    if (!p_rst_n) begin
      p_shape <= SHAPE_RESET;
      p_op    <= OP_RESET;
    end else if (sp_write && legal(res_s(sp_write_data, p_shape), res_o(sp_write_data, p_op))) begin
      p_shape <= res_s(sp_write_data, p_shape);
      p_op    <= res_o(sp_write_data, p_op);
    end
  end

  int checks = 0;
  int errors = 0;
  int excl_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int         who;
    logic       ok;
    logic [7:0] data;
    int         gap;
  } exp_t;

  exp_t        rq[$];
  logic [31:0] wq[$];
  exp_t        me;
  logic [31:0] mw;
  int          cyc = 0;
  int          last_rsp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sp_write && sp_read) excl_err++;
    if (sp_write) begin
      if (wq.size() == 0) chk("unexpected_write", {32'h0, sp_write_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        mw = wq.pop_front();
        chk("sp_write_data", {32'h0, sp_write_data}, {32'h0, mw});
      end
    end
    if (rsp_valid != '0) begin
      if (rq.size() == 0) chk("unexpected_rsp", {60'h0, rsp_valid}, 64'h0);
      else begin
        me = rq.pop_front();
        chk("rsp_valid", {60'h0, rsp_valid}, 64'(1) << me.who);
        chk("rsp_ok", {63'h0, rsp_ok}, {63'h0, me.ok});
        chk("rsp_data", {56'h0, rsp_data}, {56'h0, me.data});
        if (me.gap >= 0) chk("rsp_gap", 64'(cyc - last_rsp), 64'(me.gap));
        last_rsp = cyc;
      end
    end
  end

  task automatic issue(input int i, input logic [1:0] s, input logic [5:0] o,
                       input logic [31:0] wd, input logic ok, input logic [7:0] d, input int gap);
    exp_t e;
    e.who = i; e.ok = ok; e.data = d; e.gap = gap;
    rq.push_back(e);
    wq.push_back(wd);
    req_shape[2*i +: 2] = s;
    req_op[6*i +: 6]    = o;
    req_valid[i]        = 1'b1;
  endtask

  task automatic wait_rsp(input int i, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid[i] && lat < 40);
    if (!rsp_valid[i]) chk("rsp_seen", {63'h0, rsp_valid[i]}, 64'h1);
    req_valid[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  int lat;
  int t;

  initial begin
    req_valid = '0; req_shape = '0; req_op = '0;
    s_req = '0; s_shape = 4'b0100; s_op = 12'b000001_000000;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_rsp_valid", {60'h0, rsp_valid}, 64'h0);
    chk("rst_sp_strobes", {62'h0, sp_write, sp_read}, 64'h0);
    chk("rst_sp_write_data", {32'h0, sp_write_data}, 64'h0);
    chk("rst_reject_count", {48'h0, reject_count}, 64'h0);
    chk("rst_rsp", {55'h0, rsp_ok, rsp_data}, 64'h0);
    rst_n = 1'b1; p_rst_n = 1'b1;
    @(negedge clk);

    issue(0, 2'b01, 6'h01, 32'h0001_0001, 1'b1, 8'h41, -1);
    wait_rsp(0, lat);
    chk("latency", 64'(lat), 64'd4);
    @(negedge clk);
    issue(0, 2'b01, 6'h00, 32'h0001_0000, 1'b1, 8'h40, -1);
    wait_rsp(0, lat);
    @(negedge clk);
    issue(0, 2'b01, 6'h20, 32'h0001_0020, 1'b0, 8'h40, -1);
    wait_rsp(0, lat);
    @(negedge clk);
    chk("reject_count_1", {48'h0, reject_count}, 64'd1);
    issue(0, 2'b11, 6'h3F, 32'h0003_003F, 1'b1, 8'h40, -1);
    wait_rsp(0, lat);
    @(negedge clk);
    chk("reject_count_keep", {48'h0, reject_count}, 64'd1);
    issue(0, 2'b11, 6'h02, 32'h0003_0002, 1'b1, 8'h42, -1);
    wait_rsp(0, lat);
    @(negedge clk);
    issue(3, 2'b10, 6'h05, 32'h0002_0005, 1'b1, 8'h85, -1);
    wait_rsp(3, lat);
    @(negedge clk);

    issue(0, 2'b00, 6'h03, 32'h0000_0003, 1'b1, 8'h03, -1);
    issue(1, 2'b01, 6'h3F, 32'h0001_003F, 1'b1, 8'h43, 5);
    issue(2, 2'b01, 6'h21, 32'h0001_0021, 1'b0, 8'h43, 5);
    issue(3, 2'b11, 6'h10, 32'h0003_0010, 1'b1, 8'h50, 5);
    wait_rsp(0, lat);
    @(negedge clk);
    issue(0, 2'b10, 6'h3F, 32'h0002_003F, 1'b1, 8'h90, 5);
    wait_rsp(1, lat);
    wait_rsp(2, lat);
    wait_rsp(3, lat);
    wait_rsp(0, lat);
    @(negedge clk);
    chk("reject_count_2", {48'h0, reject_count}, 64'd2);

    // Reset in WRITE: the aborted write is still seen once, then replayed after reset.
    issue(1, 2'b10, 6'h07, 32'h0002_0007, 1'b1, 8'h87, -1);
    wq.push_back(32'h0002_0007);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!sp_write && t < 20);
    chk("write_reached", {63'h0, sp_write}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {63'h0, busy}, 64'h0);
    chk("mid_rst_strobes", {62'h0, sp_write, sp_read}, 64'h0);
    chk("mid_rst_write_data", {32'h0, sp_write_data}, 64'h0);
    chk("mid_rst_rsp", {51'h0, rsp_valid, rsp_ok, rsp_data}, 64'h0);
    chk("mid_rst_reject_count", {48'h0, reject_count}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_rsp(1, lat);
    repeat (10) @(negedge clk);

    s_req = 2'b10;
    for (int n = 1; n <= 5; n++) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!s_rsp_valid[1] && t < 40);
      chk("sat_rsp_valid", {62'h0, s_rsp_valid}, 64'h2);
      chk("sat_rsp_ok", {63'h0, s_rsp_ok}, 64'h0);
      @(negedge clk);
      chk("sat_count", {62'h0, s_reject_count}, 64'((n < 3) ? n : 3));
    end
    s_req = '0;
    repeat (6) @(negedge clk);

    chk("exclusive_strobes", 64'(excl_err), 64'h0);
    chk("rsp_queue_drained", 64'(rq.size()), 64'h0);
    chk("write_queue_drained", 64'(wq.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shape_cfg_arbiter.md
Name: shape_cfg_arbiter

Overview:
- Shares the single shape processor SFR port (write/write_data/read/read_data) between NUM_REQ software/agent requesters.
- Each granted request runs a fixed four-step sequence: capture current value, write, read back, respond.
- The read-back tells the requester whether the processor accepted the new shape/operation or silently rejected it.
- Sits directly in front of the shape processor; the processor's error output is not used.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CNT_W, 16, width of the saturating reject counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req_valid  in  NUM_REQ  per-requester request; held high until matching rsp_valid
- req_shape  in  2*NUM_REQ  requested shape, requester i at [2i+1:2i]; 2'b11 = keep current
- req_op  in  6*NUM_REQ  requested operation, requester i at [6i+5:6i]; 6'b11_1111 = keep current
- rsp_valid  out  NUM_REQ  one-hot single-cycle response pulse to the served requester
- rsp_ok  out  1  qualified by rsp_valid: 1 = read-back equals resolved request
- rsp_data  out  8  qualified by rsp_valid: read-back {shape[1:0], op[5:0]}
- sp_write  out  1  write strobe to shape processor
- sp_write_data  out  32  shape at [17:16], op at [5:0], all other bits 0
- sp_read  out  1  read strobe to shape processor
- sp_read_data  in  32  combinational read data from shape processor
- busy  out  1  FSM not in IDLE
- reject_count  out  CNT_W  number of rsp_ok=0 responses, saturating

Behaviour:
- Reset (async, clk-independent):
  - State goes to IDLE; rr_ptr goes to 0.
  - All outputs are 0: rsp_valid, rsp_ok, rsp_data, sp_write, sp_write_data, sp_read, busy, reject_count.
  - Reset mid-sequence abandons the request with no response; the requester keeps req_valid high and is re-arbitrated after reset.
- FSM states: IDLE -> CAPTURE -> WRITE -> CHECK -> RESP -> IDLE. Each non-IDLE state lasts exactly 1 cycle.
- IDLE:
  - If any req_valid is set, grant round-robin starting at rr_ptr: the first set bit at index >= rr_ptr, wrapping to index 0.
  - Register the grant index and that requester's shape/op, then go to CAPTURE.
  - No request: stay in IDLE.
- CAPTURE:
  - sp_read=1.
  - Latch pre_shape = sp_read_data[17:16] and pre_op = sp_read_data[5:0].
- WRITE:
  - sp_write=1; sp_write_data carries the registered request. Keep codes are passed through unmodified; the processor resolves them itself.
- CHECK:
  - sp_read=1.
  - Latch post = {sp_read_data[17:16], sp_read_data[5:0]}.
  - Compute expected: shape = (req_shape==2'b11) ? pre_shape : req_shape; op = (req_op==6'h3F) ? pre_op : req_op.
  - ok = (post == expected).
- RESP:
  - rsp_valid[grant]=1, rsp_ok=ok, rsp_data=post.
  - reject_count increments if !ok, saturating at all-ones.
  - rr_ptr = (grant+1) mod NUM_REQ.
- Outside RESP, rsp_valid=0 and rsp_ok/rsp_data hold their last values.
- Latency: req_valid rise in IDLE -> rsp_valid 4 cycles later at minimum. Back-to-back service throughput is one request per 5 cycles.
- busy=1 in every state except IDLE.
- Requester protocol:
  - req_valid and data must stay stable from assertion until the rsp_valid cycle.
  - Deassert, or present a new request, in the cycle after rsp_valid.
  - A requester dropping req_valid before its response is a protocol violation. Its request still completes and rsp_valid still fires.
- sp_write and sp_read are never asserted in the same cycle.
- Boundaries:
  - rr_ptr wraps NUM_REQ-1 -> 0.
  - A requester re-asserting immediately after its response waits behind all other pending requesters (fairness).
  - A request with both keep codes always returns ok=1 with rsp_data = pre value.
  - reject_count holds once saturated.

Decomposition:
- Package shape_pkg:
  - shape_t (2b), operation_t (6b).
  - Constants SHAPE_KEEP=2'b11, OP_KEEP=6'h3F, SHAPE_LSB=16, OP_LSB=0, SHAPE_RESET=2'b01, OP_RESET=6'h00.
  - fsm_state_t enum.
- Sub-module rr_arbiter (NUM_REQ): combinational round-robin pick from req_valid and rr_ptr, outputs grant index and any_valid.

Test Plan:
- After reset, requester 0 sends shape=01, op=00_0001 -> sp_write_data=0x0001_0001; rsp_valid=0001 at cycle 4; rsp_ok=1; rsp_data=8'h41.
- Illegal combination shape=01, op=10_0000 from state 01/00_0000 -> processor rejects; rsp_ok=0; rsp_data=8'h40; reject_count=1.
- Keep codes shape=11, op=3F -> rsp_ok=1; rsp_data equals pre value; no change in state.
- All 4 requesters assert in the same cycle with rr_ptr=0 -> responses in order 0,1,2,3, 5 cycles apart; requester 0 re-asserts after its response and is served after 3.
- rst_n asserted during WRITE -> all outputs 0 immediately; after release, the still-pending requester is served and gets exactly one rsp_valid.
- Force reject_count to saturate (CNT_W=2 build, 5 rejects) -> count holds at 3.
